// File: rtl/dmem_fill_resp.sv
// dmem_fill_resp: answers data-cache line refills by reading the line from a
// narrower memory port one beat at a time and returning the assembled line
// with a single-cycle valid pulse.
module dmem_fill_resp #(
    parameter int unsigned LINE_W  = 512,
    parameter int unsigned BLK_LEN = 58,
    parameter int unsigned BEAT_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLK_LEN-1:0] b_addr_d,
    input  logic               b_rd_d,
    output logic [LINE_W-1:0]  b_rdata_d,
    output logic               b_dv_d,
    output logic [63:0]        m_addr,
    output logic               m_rd,
    input  logic               m_ready,
    input  logic [BEAT_W-1:0]  m_rdata,
    input  logic               m_rvalid,
    output logic               busy
);

    localparam int unsigned BEATS  = LINE_W / BEAT_W;
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(BEAT_W / 8);
    localparam int unsigned ADDR_W = 64;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [BLK_LEN-1:0] blk_q;
    logic [IDX_W-1:0]   idx_q;
    logic               abort_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  line_wr;

    // Byte address of beat idx within block blk: {blk, idx, zero byte offset}.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [BLK_LEN-1:0] blk,
                                                    input logic [IDX_W-1:0]   idx);
        return ADDR_W'({blk, idx, OFF_W'(0)});
    endfunction

    // Line buffer with the incoming beat merged in, so the final beat can be
    // returned on the same edge it is captured.
    always_comb begin
        line_wr = line_q;
        line_wr[int'(idx_q) * BEAT_W +: BEAT_W] = m_rdata;
    end

    // Fill sequencer: request beats in ascending order, collect them, and
    // publish the line unless the requester withdrew mid-fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            blk_q     <= '0;
            idx_q     <= '0;
            abort_q   <= 1'b0;
            line_q    <= '0;
            b_rdata_d <= '0;
            b_dv_d    <= 1'b0;
            m_addr    <= '0;
            m_rd      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            b_dv_d <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (b_rd_d) begin
                        blk_q   <= b_addr_d;
                        idx_q   <= '0;
                        abort_q <= 1'b0;
                        m_rd    <= 1'b1;
                        m_addr  <= beat_addr(b_addr_d, '0);
                        busy    <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!b_rd_d) begin
                        abort_q <= 1'b1;
                    end
                    if (m_ready) begin
                        m_rd    <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!b_rd_d) begin
                        abort_q <= 1'b1;
                    end
                    if (m_rvalid) begin
                        line_q <= line_wr;
                        if (idx_q != LAST_IDX) begin
                            idx_q   <= idx_q + IDX_W'(1);
                            m_rd    <= 1'b1;
                            m_addr  <= beat_addr(blk_q, idx_q + IDX_W'(1));
                            state_q <= REQ;
                        end else if (abort_q || !b_rd_d) begin
                            // Withdrawn fill: drain finished, drop the line.
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            b_dv_d    <= 1'b1;
                            b_rdata_d <= line_wr;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    m_rd    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_fill_resp.sv
// tb_dmem_fill_resp: directed refill scenarios against a scoreboarded memory
// responder with configurable ready and response delays.
module tb_dmem_fill_resp;

    localparam int unsigned LINE_W  = 512;
    localparam int unsigned BLK_LEN = 58;
    localparam int unsigned BEAT_W  = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [BLK_LEN-1:0] b_addr_d;
    logic               b_rd_d;
    logic [LINE_W-1:0]  b_rdata_d;
    logic               b_dv_d;
    logic [63:0]        m_addr;
    logic               m_rd;
    logic               m_ready;
    logic [BEAT_W-1:0]  m_rdata;
    logic               m_rvalid;
    logic               busy;

    dmem_fill_resp #(
        .LINE_W  (LINE_W),
        .BLK_LEN (BLK_LEN),
        .BEAT_W  (BEAT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b_addr_d  (b_addr_d),
        .b_rd_d    (b_rd_d),
        .b_rdata_d (b_rdata_d),
        .b_dv_d    (b_dv_d),
        .m_addr    (m_addr),
        .m_rd      (m_rd),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0]  exp_addr_q[$];
    logic [511:0] exp_line_q[$];

    int          rdy_dly  = 0;
    int          rv_dly   = 1;
    int unsigned tag      = 0;
    int          n_acc    = 0;
    int          dv_count = 0;
    int          rv_cnt   = 0;
    int          wait_cnt = 0;
    logic [63:0] hold_addr;
    logic [63:0] pend;
    logic [511:0] last_line = '0;

    task automatic check(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdata(input int unsigned t, input logic [2:0] beat);
        return 64'h1111_0000_0000_0000 + (64'(t) << 16) + 64'(beat);
    endfunction

    function automatic logic [511:0] mline(input int unsigned t);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = mdata(t, 3'(i));
        return l;
    endfunction

    function automatic logic [63:0] baddr(input logic [57:0] blk, input int i);
        return {blk, 6'd0} + 64'(i * 8);
    endfunction

    task automatic push_addrs(input logic [57:0] blk);
        for (int i = 0; i < 8; i++) exp_addr_q.push_back(baddr(blk, i));
    endtask

    // Memory responder: stalls m_ready, then returns the beat rv_dly cycles later.
    initial begin
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ready  = 1'b0;
                m_rvalid = 1'b0;
                rv_cnt   = 0;
                wait_cnt = 0;
            end else begin
                m_rvalid = 1'b0;
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        m_rvalid = 1'b1;
                        m_rdata  = pend;
                    end
                end
                m_ready = 1'b0;
                if (m_rd === 1'b1) begin
                    if (wait_cnt == 0) hold_addr = m_addr;
                    else check("m_addr_stable", m_addr, hold_addr);
                    if (wait_cnt >= rdy_dly) begin
                        m_ready  = 1'b1;
                        wait_cnt = 0;
                        rv_cnt   = rv_dly;
                        pend     = mdata(tag, m_addr[5:3]);
                        n_acc++;
                        n_vec++;
                        assert (exp_addr_q.size() > 0) else begin
                            n_err++;
                            $error("FAIL m_addr_extra: observed request %0h expected none", m_addr);
                        end
                        if (exp_addr_q.size() > 0) check("m_addr", m_addr, exp_addr_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Line monitor: every b_dv_d pulse must match the oldest expected line.
    initial forever begin
        @(negedge clk);
        if (!rst && b_dv_d === 1'b1) begin
            dv_count++;
            n_vec++;
            assert (exp_line_q.size() > 0) else begin
                n_err++;
                $error("FAIL dv_spurious: observed pulse expected none");
            end
            if (exp_line_q.size() > 0) check("line", b_rdata_d, exp_line_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic run_fill(input logic [57:0] blk, input int unsigned t, input int rd, input int vd,
                            input bit pre, input int chg_at, input logic [57:0] chg_blk,
                            input bit chain, input logic [57:0] next_blk);
        int n;
        bit seen;
        rdy_dly = rd;
        rv_dly  = vd;
        tag     = t;
        push_addrs(blk);
        exp_line_q.push_back(mline(t));
        if (!pre) begin
            @(negedge clk);
            b_addr_d = blk;
            b_rd_d   = 1'b1;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (n == chg_at) b_addr_d = chg_blk;
            if (b_dv_d === 1'b1) seen = 1'b1;
        end
        check("dv_seen", seen, 1'b1);
        check("latency", n, 1 + 8 * (rd + 1 + vd));
        last_line = mline(t);
        if (chain) begin
            b_addr_d = next_blk;
            b_rd_d   = 1'b1;
        end else begin
            b_rd_d = 1'b0;
        end
        @(negedge clk);
        check("dv_single", b_dv_d, 1'b0);
    endtask

    initial begin
        int start;
        int dvc;
        int k;
        b_addr_d = '0;
        b_rd_d   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_rd", m_rd, 1'b0);
        check("rst_dv", b_dv_d, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_m_addr", m_addr, 64'h0);
        check("rst_rdata", b_rdata_d, 512'h0);
        rst = 1'b0;

        // Basic zero-wait fill
        run_fill(58'h2A, 0, 0, 1, 1'b0, 0, '0, 1'b0, '0);
        check("basic_beat0", b_rdata_d[63:0], 64'h1111_0000_0000_0000);
        check("basic_beat7", b_rdata_d[511:448], 64'h1111_0000_0000_0007);
        check("basic_dv_count", dv_count, 1);

        // Backpressure: ready after 3 stalls, data 2 cycles after acceptance
        run_fill(58'h2A, 0, 3, 2, 1'b0, 0, '0, 1'b0, '0);
        check("bp_line", b_rdata_d, mline(0));

        // Address changes mid-fill are ignored; next fill uses the new one
        run_fill(58'h2A, 1, 0, 1, 1'b0, 5, 58'h7, 1'b0, '0);
        run_fill(58'h7, 2, 0, 1, 1'b0, 0, '0, 1'b0, '0);

        // Abort during beat 3
        start   = n_acc;
        dvc     = dv_count;
        rdy_dly = 0;
        rv_dly  = 1;
        tag     = 6;
        push_addrs(58'h30);
        @(negedge clk);
        b_addr_d = 58'h30;
        b_rd_d   = 1'b1;
        k = 0;
        while (n_acc < start + 4 && k < 200) begin
            @(negedge clk); #1; k++;
        end
        b_rd_d = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk); #1; k++;
        end
        check("abort_beats", n_acc - start, 8);
        check("abort_addr_left", exp_addr_q.size(), 0);
        check("abort_no_dv", dv_count, dvc);
        check("abort_rdata_hold", b_rdata_d, last_line);
        check("abort_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_no_late_dv", dv_count, dvc);

        // Async reset in WAIT of beat 5
        start   = n_acc;
        rdy_dly = 0;
        rv_dly  = 2;
        tag     = 7;
        push_addrs(58'h11);
        @(negedge clk);
        b_addr_d = 58'h11;
        b_rd_d   = 1'b1;
        k = 0;
        while (n_acc < start + 6 && k < 200) begin
            @(negedge clk); #1; k++;
        end
        @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_m_rd", m_rd, 1'b0);
        check("arst_dv", b_dv_d, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_m_addr", m_addr, 64'h0);
        exp_addr_q.delete();
        exp_line_q.delete();
        b_rd_d = 1'b0;
        @(negedge clk);
        #1;
        check("arst_rdata", b_rdata_d, 512'h0);
        rst = 1'b0;
        run_fill(58'h11, 8, 0, 1, 1'b0, 0, '0, 1'b0, '0);

        // Back-to-back fills
        dvc = dv_count;
        run_fill(58'h2A, 3, 0, 1, 1'b0, 0, '0, 1'b1, 58'h2B);
        run_fill(58'h2B, 4, 0, 1, 1'b1, 0, '0, 1'b0, '0);
        repeat (5) @(negedge clk);
        check("b2b_dv_count", dv_count, dvc + 2);
        check("b2b_idle", busy, 1'b0);
        check("b2b_addr_left", exp_addr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_fill_resp.md
Name: dmem_fill_resp

Overview:
Memory-side responder for the data-cache line-refill interface. It accepts a block-address read request from the data cache and reads the line from a narrower external memory port, one beat at a time. It assembles the beats into a full cache line, then returns the line with a single-cycle data-valid pulse. It sits between the core's dmem refill port and the system memory/interconnect.

Parameters:
LINE_W, 512, cache line width in bits; must be a multiple of BEAT_W (matches DMEM_LINE).
BLK_LEN, 58, block-address width; equals 64 - log2(LINE_W/8) (matches DMEM_BLK_LEN).
BEAT_W, 64, external memory data width in bits.
BEATS, LINE_W/BEAT_W, beats per line (derived, 8 by default).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous active-high reset.
b_addr_d  in  BLK_LEN  requested line block address; valid while b_rd_d=1.
b_rd_d  in  1  refill request from dmem; level, held until b_dv_d is seen.
b_rdata_d  out  LINE_W  assembled line; valid in the b_dv_d cycle.
b_dv_d  out  1  line-valid pulse, exactly one cycle per completed fill.
m_addr  out  64  byte address of the current beat.
m_rd  out  1  beat read request; held until m_ready.
m_ready  in  1  memory accepts the beat request this cycle when m_rd=1.
m_rdata  in  BEAT_W  beat read data.
m_rvalid  in  1  beat data valid; at most one per accepted request; earliest one cycle after acceptance.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0, abort flag=0, b_dv_d=0, m_rd=0, m_addr=0, b_rdata_d=0, busy=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If b_rd_d=1, latch b_addr_d into blk_q, set beat counter=0, clear the abort flag, and go to REQ.
  - b_addr_d is sampled only here; later changes are ignored.
- REQ:
  - m_rd=1, with m_addr = {blk_q, beat_idx, log2(BEAT_W/8) zero bits}, where beat_idx is log2(BEATS) bits.
  - On m_ready=1, go to WAIT.
- WAIT:
  - m_rd=0.
  - On m_rvalid=1, write m_rdata into line_q[idx*BEAT_W +: BEAT_W].
  - If idx < BEATS-1: increment idx and go to REQ.
  - Else (last beat): go to DONE, or go to IDLE if the abort flag is set.
- DONE:
  - b_dv_d=1 for exactly this one cycle; b_rdata_d = line_q.
  - Unconditionally go to IDLE.
  - The dmem leaves its fetch state on the same edge, so b_rd_d is low in the following IDLE cycle; no retrigger.
- b_rdata_d is registered. It is updated only on fill completion and holds the last line otherwise.
- Beats fill in ascending address order; beat 0 goes to line bits [BEAT_W-1:0] (little-endian line).
- Abort: if b_rd_d falls while in REQ or WAIT, set the abort flag. All remaining beats are still issued and consumed (memory transactions cannot be cancelled). The fill then ends in IDLE with no b_dv_d pulse, and b_rdata_d is unchanged.
- If b_rd_d is high in the IDLE cycle after an aborted fill, a new fill starts with the new address.
- m_rvalid outside WAIT is ignored. m_ready outside REQ is ignored.
- Fill latency with a zero-wait memory (m_ready=1 in REQ, m_rvalid one cycle after acceptance):
  - b_rd_d rises at cycle 0; IDLE→REQ at the end of cycle 0.
  - 2 cycles per beat.
  - b_dv_d asserts in cycle 1 + 2*BEATS (cycle 17 for BEATS=8).
- busy=1 in REQ, WAIT and DONE.

Test Plan:
- Basic fill:
  - Stimulus: reset, b_addr_d=0x2A, b_rd_d=1; zero-wait memory returns beat i = 0x1111_0000_0000_0000+i.
  - Required: m_addr = 0xA80, 0xA88, …, 0xAB8 in order.
  - Required: b_dv_d high exactly one cycle, at cycle 17.
  - Required: b_rdata_d[63:0] = 0x1111_0000_0000_0000, b_rdata_d[511:448] = 0x1111_0000_0000_0007.
- Backpressure:
  - Stimulus: m_ready low 3 cycles per beat, m_rvalid delayed 2 cycles after acceptance.
  - Required: m_rd held with a stable m_addr until m_ready; line contents identical to the basic fill.
  - Required: b_dv_d at cycle 1 + 8*(4+2) = 49.
- Address stability:
  - Stimulus: change b_addr_d to 0x7 mid-fill.
  - Required: all m_addr values remain in 0xA80–0xAB8.
  - Required: the next request after b_dv_d uses the new address (0x1C0 base).
- Abort:
  - Stimulus: drop b_rd_d during beat 3.
  - Required: beats 3–7 are still requested; no b_dv_d; b_rdata_d keeps its previous value; busy falls after beat 7.
- Async reset mid-fill:
  - Stimulus: assert rst during WAIT of beat 5 with no clock edge.
  - Required: m_rd, b_dv_d and busy go to 0 immediately.
  - Required: a fresh fill after release starts at beat 0.
- Back-to-back fills:
  - Stimulus: b_rd_d reasserted in the IDLE cycle following DONE with b_addr_d=0x2B.
  - Required: the second fill starts at m_addr 0xAC0; two distinct b_dv_d pulses; no spurious extra pulse.
